// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch unit.
//   state_t          : fetch FSM states (IDLE, BUS, DONE)
//   NOP_WORD_DEFAULT : word placed in IR on reset and on any fetch error (MOV r0,r0)
//   ALIGN_MASK       : PC bits that must be zero for a word-aligned fetch
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'hE1A0_0000;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

endpackage

// File: rtl/instr_fetch_unit_timer.sv
// fetch_timer: saturating cycle counter used to bound a bus read.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear (takes priority over en)
//   en       : count one cycle
//   expired  : counter has reached TIMEOUT-1, i.e. this is the last allowed cycle
// Only instantiated when TIMEOUT != 0.
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned   W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0]  MAX  = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: answers the controller's IR-write request with one word
// read from instruction memory, loads the result into the instruction
// register and pulses ir_valid. Misaligned PCs and bus timeouts load NOP_WORD
// and pulse fetch_err, so the controller's fetch wait always terminates.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   fetch_req         : fetch request (controller write_ir), may stay high
//   pc_in[31:0]       : fetch address, sampled when a request is accepted
//   ir_out[31:0]      : instruction register
//   ir_valid          : one-cycle pulse, ir_out was just updated
//   fetch_err         : one-cycle pulse with ir_valid when the fetch failed
//   busy              : high in BUS and DONE
//   mem_addr[31:0]    : instruction memory address
//   mem_rd            : read strobe, held until ack or timeout
//   mem_rdata[31:0]   : read data, valid with mem_ack
//   mem_ack           : read complete
// All outputs come straight from flops.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] pc_in,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    output logic        fetch_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_t      state, state_next;
    logic [31:0] ir_next, addr_next;
    logic        valid_next, err_next, rd_next, busy_next;
    logic        expired;

    // The timer is held clear outside BUS, so its count equals the number of
    // completed BUS cycles of the current read.
    generate
        if (TIMEOUT != 0) begin : g_timer
            fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
                .clk     (clk),
                .rst     (rst),
                .clear   (state != BUS),
                .en      (state == BUS),
                .expired (expired)
            );
        end else begin : g_no_timer
            assign expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_next = state;
        ir_next    = ir_out;
        addr_next  = mem_addr;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    if ((pc_in[1:0] & ALIGN_MASK) == 2'b00) begin
                        addr_next  = pc_in;
                        state_next = BUS;
                    end else begin
                        ir_next    = NOP_WORD;
                        valid_next = 1'b1;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            BUS: begin
                // Ack is checked first so a simultaneous ack and timeout delivers data.
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    valid_next = 1'b1;
                    state_next = DONE;
                end else if (expired) begin
                    ir_next    = NOP_WORD;
                    valid_next = 1'b1;
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Holdoff: a still-high fetch_req must not start a second fetch.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        rd_next   = (state_next == BUS);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ir_out    <= NOP_WORD;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_next;
            ir_out    <= ir_next;
            ir_valid  <= valid_next;
            fetch_err <= err_next;
            busy      <= busy_next;
            mem_rd    <= rd_next;
            mem_addr  <= addr_next;
        end
    end

endmodule
